// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-write-port bundle for fifo_wr_arbiter.
// master = producers plus FIFO side (testbench); slave = the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DATASIZE-1:0] req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     wfull;
    logic                     winc;
    logic [DATASIZE-1:0]      wdata;
    logic [NREQ-1:0]          gnt;
    logic                     busy;

    modport master (
        output req_valid, req_data, wfull,
        input  req_ready, winc, wdata, gnt, busy
    );

    modport slave (
        input  req_valid, req_data, wfull,
        output req_ready, winc, wdata, gnt, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// A grant is issued combinationally and lasts for a burst of up to MAXBURST words.
module fifo_wr_arbiter #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAXBURST + 1);
    localparam logic [IW-1:0] LAST_RST  = IW'(NREQ - 1);
    localparam logic [BW-1:0] BURST_LEN = BW'(MAXBURST);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [BW-1:0]   bcnt_q,  bcnt_d;

    logic [IW-1:0]       sel;
    logic [IW-1:0]       cur;
    logic                any_valid;
    logic                granted;
    logic                xfer;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     req_ready;
    logic [DATASIZE-1:0] wdata;

    // Round-robin search: walking offsets downward leaves the nearest valid producer after last.
    always_comb begin
        logic [IW-1:0] idx;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        sel = '0;
        idx = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = IW'((int'(last_q) + off) % NREQ);
            if (bus.req_valid[idx]) sel = idx;
        end
    end

    assign any_valid = |bus.req_valid;
    assign cur       = (state_q == BUSY) ? owner_q : sel;
    // Gating with wrst keeps the combinational grant quiet while reset is held.
    assign granted   = !wrst && ((state_q == BUSY) || any_valid);
    assign xfer      = granted && bus.req_valid[cur] && !bus.wfull;

    always_comb begin
        gnt       = '0;
        req_ready = '0;
        wdata     = '0;
        if (granted) begin
            gnt[cur] = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (cur == IW'(i)) wdata = bus.req_data[i*DATASIZE +: DATASIZE];
            end
        end
        if (xfer) req_ready[cur] = 1'b1;
    end

    assign bus.gnt       = gnt;
    assign bus.req_ready = req_ready;
    assign bus.wdata     = wdata;
    assign bus.winc      = xfer;
    assign bus.busy      = (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    if (xfer && (MAXBURST == 1)) begin
                        last_d = sel;
                    end else begin
                        state_d = BUSY;
                        owner_d = sel;
                        bcnt_d  = xfer ? BW'(1) : '0;
                    end
                end
            end
            BUSY: begin
                // A producer that drops valid forfeits the rest of its burst.
                if (!bus.req_valid[owner_q]) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    bcnt_d  = '0;
                end else if (xfer) begin
                    if (bcnt_q + BW'(1) == BURST_LEN) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            bcnt_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector tables, hand sequences,
// and a randomized run against a credit-based round-robin reference model.
module tb_fifo_wr_arbiter;
    localparam int DS = 8;
    localparam int NR = 4;

    logic wclk = 1'b0;
    logic wrst;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.DATASIZE(DS), .NREQ(NR)) bus_a ();
    fifo_wr_arbiter_if #(.DATASIZE(DS), .NREQ(NR)) bus_b ();

    fifo_wr_arbiter #(.DATASIZE(DS), .NREQ(NR), .MAXBURST(4)) dut_a (
        .wclk(wclk), .wrst(wrst), .bus(bus_a)
    );
    fifo_wr_arbiter #(.DATASIZE(DS), .NREQ(NR), .MAXBURST(1)) dut_b (
        .wclk(wclk), .wrst(wrst), .bus(bus_b)
    );

    typedef struct {
        logic [NR-1:0] valid;
        logic          wfull;
        logic [NR-1:0] gnt;
        logic          winc;
        logic [DS-1:0] wdata;
        logic          busy;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DS-1:0] dat(input int idx);
        return DS'((idx + 1) * 17);
    endfunction

    function automatic vec_t mk(input logic [NR-1:0] valid, input logic wfull,
                                input logic [NR-1:0] gnt, input logic winc, input logic busy);
        vec_t v;
        v.valid = valid; v.wfull = wfull; v.gnt = gnt; v.winc = winc; v.busy = busy;
        v.wdata = '0;
        for (int i = 0; i < NR; i++) if (gnt[i]) v.wdata = dat(i);
        return v;
    endfunction

    task automatic apply_a(input vec_t v, input string tag);
        @(negedge wclk);
        bus_a.req_valid = v.valid;
        bus_a.wfull     = v.wfull;
        #1;
        check({tag, ".gnt"},   32'(bus_a.gnt),       32'(v.gnt));
        check({tag, ".ready"}, 32'(bus_a.req_ready), v.winc ? 32'(v.gnt) : 32'd0);
        check({tag, ".winc"},  32'(bus_a.winc),      32'(v.winc));
        check({tag, ".busy"},  32'(bus_a.busy),      32'(v.busy));
        if (v.winc || v.gnt == '0) check({tag, ".wdata"}, 32'(bus_a.wdata), 32'(v.wdata));
    endtask

    task automatic do_reset(input string tag);
        wrst = 1'b1;
        bus_a.req_valid = '1; bus_b.req_valid = '1;
        bus_a.wfull = 1'b0;   bus_b.wfull = 1'b0;
        #1;
        check({tag, ".rst.gnt"},  32'(bus_a.gnt),       32'd0);
        check({tag, ".rst.rdy"},  32'(bus_a.req_ready), 32'd0);
        check({tag, ".rst.winc"}, 32'(bus_a.winc),      32'd0);
        @(negedge wclk);
        bus_a.req_valid = '0; bus_b.req_valid = '0;
        wrst = 1'b0;
        #1;
        check({tag, ".idle.gnt"},   32'(bus_a.gnt),   32'd0);
        check({tag, ".idle.wdata"}, 32'(bus_a.wdata), 32'd0);
        check({tag, ".idle.busy"},  32'(bus_a.busy),  32'd0);
    endtask

    // Reference model: per instance an owner (-1 = none), remaining burst credits and last winner.
    int m_owner[2];
    int m_cred[2];
    int m_last[2];
    int m_burst[2] = '{4, 1};
    int winc_cnt[2];
    int ready_cnt[2];
    int model_cnt[2];

    initial begin
        vec_t t1[17];
        vec_t seq[$];
        logic [NR-1:0]          rv;
        logic                   rf;
        logic [NR*DS-1:0]       rd;
        logic [NR-1:0]          a_gnt[2], a_rdy[2];
        logic                   a_winc[2], a_busy[2];
        logic [DS-1:0]          a_wdata[2];

        bus_a.req_data = {dat(3), dat(2), dat(1), dat(0)};
        bus_b.req_data = '0;

        // Test 1: all valid, MAXBURST=4 -> four-word bursts rotating with no bubble.
        for (int c = 0; c < 17; c++)
            t1[c] = mk('1, 1'b0, NR'(1) << ((c / 4) % NR), 1'b1, (c % 4) != 0);
        do_reset("t1");
        for (int c = 0; c < 17; c++) apply_a(t1[c], $sformatf("t1[%0d]", c));

        // Test 2: single producer 2 on the MAXBURST=1 instance, a write every cycle.
        do_reset("t2");
        bus_b.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        for (int c = 0; c < 6; c++) begin
            @(negedge wclk);
            bus_b.req_valid = 4'b0100;
            #1;
            check($sformatf("t2[%0d].gnt", c),   32'(bus_b.gnt),       32'h4);
            check($sformatf("t2[%0d].rdy", c),   32'(bus_b.req_ready), 32'h4);
            check($sformatf("t2[%0d].winc", c),  32'(bus_b.winc),      32'h1);
            check($sformatf("t2[%0d].wdata", c), 32'(bus_b.wdata),     32'hA5);
            check($sformatf("t2[%0d].busy", c),  32'(bus_b.busy),      32'h0);
        end

        // Test 3: owner 1 stalled by wfull mid-burst, then finishes its remaining two words.
        do_reset("t3");
        seq = {};
        seq.push_back(mk(4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0));
        seq.push_back(mk(4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1));
        repeat (3) seq.push_back(mk(4'b1111, 1'b1, 4'b0010, 1'b0, 1'b1));
        repeat (2) seq.push_back(mk(4'b1111, 1'b0, 4'b0010, 1'b1, 1'b1));
        seq.push_back(mk(4'b1111, 1'b0, 4'b0100, 1'b1, 1'b0));
        foreach (seq[i]) apply_a(seq[i], $sformatf("t3[%0d]", i));

        // Test 4: owner 0 drops valid after two words; one bubble, then producer 3.
        do_reset("t4");
        seq = {};
        seq.push_back(mk(4'b1001, 1'b0, 4'b0001, 1'b1, 1'b0));
        seq.push_back(mk(4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1));
        seq.push_back(mk(4'b1000, 1'b0, 4'b0001, 1'b0, 1'b1));
        seq.push_back(mk(4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0));
        repeat (2) seq.push_back(mk(4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1));
        foreach (seq[i]) apply_a(seq[i], $sformatf("t4[%0d]", i));

        // Test 5: reset asserted mid-burst of owner 2; outputs drop at once, restart at producer 0.
        do_reset("t5");
        apply_a(mk(4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0), "t5[0]");
        apply_a(mk(4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1), "t5[1]");
        @(negedge wclk);
        bus_a.req_valid = '1;
        wrst = 1'b1;
        #1;
        check("t5.mid.gnt",   32'(bus_a.gnt),       32'd0);
        check("t5.mid.rdy",   32'(bus_a.req_ready), 32'd0);
        check("t5.mid.winc",  32'(bus_a.winc),      32'd0);
        check("t5.mid.wdata", 32'(bus_a.wdata),     32'd0);
        check("t5.mid.busy",  32'(bus_a.busy),      32'd0);
        @(negedge wclk);
        wrst = 1'b0;
        #1;
        check("t5.rel.gnt",   32'(bus_a.gnt),   32'h1);
        check("t5.rel.winc",  32'(bus_a.winc),  32'h1);
        check("t5.rel.wdata", 32'(bus_a.wdata), 32'(dat(0)));

        // Test 6: random valid/wfull/data on both instances against the reference model.
        do_reset("t6");
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1; m_cred[m] = 0; m_last[m] = NR - 1;
            winc_cnt[m] = 0; ready_cnt[m] = 0; model_cnt[m] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge wclk);
            for (int i = 0; i < NR; i++) rv[i] = ($urandom_range(3) != 0);
            rf = ($urandom_range(3) == 0);
            rd = NR*DS'($urandom);
            bus_a.req_valid = rv; bus_a.wfull = rf; bus_a.req_data = rd;
            bus_b.req_valid = rv; bus_b.wfull = rf; bus_b.req_data = rd;
            #1;
            a_gnt[0] = bus_a.gnt; a_rdy[0] = bus_a.req_ready; a_winc[0] = bus_a.winc;
            a_busy[0] = bus_a.busy; a_wdata[0] = bus_a.wdata;
            a_gnt[1] = bus_b.gnt; a_rdy[1] = bus_b.req_ready; a_winc[1] = bus_b.winc;
            a_busy[1] = bus_b.busy; a_wdata[1] = bus_b.wdata;
            for (int m = 0; m < 2; m++) begin
                int cur;
                logic x;
                logic [NR-1:0] eg;
                cur = m_owner[m];
                if (cur < 0) begin
                    for (int off = 1; off <= NR; off++) begin
                        if (cur < 0 && rv[(m_last[m] + off) % NR]) cur = (m_last[m] + off) % NR;
                    end
                end
                eg = (cur >= 0) ? (NR'(1) << cur) : '0;
                x  = (cur >= 0) && rv[cur] && !rf;
                check($sformatf("t6[%0d].m%0d.gnt", c, m),  32'(a_gnt[m]),  32'(eg));
                check($sformatf("t6[%0d].m%0d.rdy", c, m),  32'(a_rdy[m]),  x ? 32'(eg) : 32'd0);
                check($sformatf("t6[%0d].m%0d.winc", c, m), 32'(a_winc[m]), 32'(x));
                check($sformatf("t6[%0d].m%0d.busy", c, m), 32'(a_busy[m]), 32'(m_owner[m] >= 0));
                if (x)
                    check($sformatf("t6[%0d].m%0d.wdata", c, m), 32'(a_wdata[m]), 32'(rd[cur*DS +: DS]));
                check($sformatf("t6[%0d].m%0d.inv", c, m),
                      32'({a_winc[m] == (|a_rdy[m]), !(a_winc[m] && rf), $onehot0(a_rdy[m])}), 32'h7);
                winc_cnt[m]  += int'(a_winc[m]);
                ready_cnt[m] += $countones(a_rdy[m]);
                model_cnt[m] += int'(x);
                if (cur >= 0) begin
                    if (m_owner[m] < 0) begin
                        m_owner[m] = cur;
                        m_cred[m]  = m_burst[m];
                    end
                    if (!rv[cur]) begin
                        m_owner[m] = -1; m_last[m] = cur;
                    end else if (x) begin
                        m_cred[m]--;
                        if (m_cred[m] == 0) begin
                            m_owner[m] = -1; m_last[m] = cur;
                        end
                    end
                end
            end
        end
        for (int m = 0; m < 2; m++) begin
            check($sformatf("t6.m%0d.winc_vs_ready", m), 32'(winc_cnt[m]), 32'(ready_cnt[m]));
            check($sformatf("t6.m%0d.winc_vs_model", m), 32'(winc_cnt[m]), 32'(model_cnt[m]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
